// File: rtl/spi_frame_sequencer_if.sv
// Bundle of requester-side and spi_master-side signals around the frame sequencer.
// The sequencer connects through the slave modport. The requester and the byte engine connect through master.
interface spi_frame_sequencer_if #(
    parameter int unsigned LEN_W = 4
);
    // Requester side
    logic             frm_req;
    logic [LEN_W-1:0] frm_len;
    logic             frm_abort;
    logic             frm_busy;
    logic             frm_done;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_take;
    logic [7:0]       rx_byte;
    logic             rx_valid;

    // Single-byte spi_master side
    logic             spi_start;
    logic [7:0]       spi_tx_data;
    logic [7:0]       spi_rx_data;
    logic             spi_tx_ready;
    logic             spi_done;
    logic             ss_n;

    modport slave (
        input  frm_req, frm_len, frm_abort, tx_byte, tx_valid,
               spi_rx_data, spi_tx_ready, spi_done,
        output frm_busy, frm_done, tx_take, rx_byte, rx_valid,
               spi_start, spi_tx_data, ss_n
    );

    modport master (
        output frm_req, frm_len, frm_abort, tx_byte, tx_valid,
               spi_rx_data, spi_tx_ready, spi_done,
        input  frm_busy, frm_done, tx_take, rx_byte, rx_valid,
               spi_start, spi_tx_data, ss_n
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Whole-frame chip-select controller in front of a single-byte spi_master.
// It enforces the CS setup, hold and inter-frame gap, and streams bytes one at a time.
module spi_frame_sequencer #(
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_frame_sequencer_if.slave  bus
);
    localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD)
                                      ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                                      : ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ss_n_q, ss_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             take_q, take_d;
    logic             rxv_q, rxv_d;
    logic             start_q, start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       rx_byte_q, rx_byte_d;

    logic             fetch_now;
    logic             launch_ok;

    // The last SETUP cycle acts as a fetch cycle. This makes the first spi_start land exactly CS_SETUP cycles after ss_n falls.
    assign fetch_now = (state_q == ST_FETCH) ||
                       ((state_q == ST_SETUP) && (cnt_q == CNT_W'(1)));
    assign launch_ok = bus.tx_valid & bus.spi_tx_ready & ~bus.frm_abort;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        take_d    = 1'b0;
        rxv_d     = 1'b0;
        start_d   = 1'b0;
        tx_data_d = tx_data_q;
        rx_byte_d = rx_byte_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.frm_req && (bus.frm_len != '0)) begin
                    rem_d   = bus.frm_len;
                    cnt_d   = CNT_W'(CS_SETUP);
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: cnt_d = cnt_q - 1'b1;
            ST_FETCH: ;
            ST_WAIT: begin
                if (bus.spi_done) begin
                    rx_byte_d = bus.spi_rx_data;
                    rxv_d     = 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if ((rem_q == LEN_W'(1)) || bus.frm_abort) begin
                        cnt_d   = CNT_W'(CS_HOLD);
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = CNT_W'(IDLE_GAP);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fetch_now) begin
            if (bus.frm_abort) begin
                cnt_d   = CNT_W'(CS_HOLD);
                state_d = ST_HOLD;
            end else if (launch_ok) begin
                take_d    = 1'b1;
                start_d   = 1'b1;
                tx_data_d = bus.tx_byte;
                state_d   = ST_WAIT;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            take_q    <= 1'b0;
            rxv_q     <= 1'b0;
            start_q   <= 1'b0;
            tx_data_q <= 8'h00;
            rx_byte_q <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            take_q    <= take_d;
            rxv_q     <= rxv_d;
            start_q   <= start_d;
            tx_data_q <= tx_data_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    assign bus.ss_n        = ss_n_q;
    assign bus.frm_busy    = busy_q;
    assign bus.frm_done    = done_q;
    assign bus.tx_take     = take_q;
    assign bus.rx_valid    = rxv_q;
    assign bus.spi_start   = start_q;
    assign bus.spi_tx_data = tx_data_q;
    assign bus.rx_byte     = rx_byte_q;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer. It uses a simple byte-engine model and tx/rx scoreboard queues,
// and checks cycle-level timing through event timestamps.
module tb_spi_frame_sequencer;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned CS_SETUP = 4;
    localparam int unsigned CS_HOLD  = 4;
    localparam int unsigned IDLE_GAP = 2;
    localparam int          BOUND    = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_frame_sequencer_if #(.LEN_W(LEN_W)) ifc ();

    spi_frame_sequencer #(
        .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] feed[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] resp[$];

    int n_start = 0, n_take = 0, n_rxv = 0, n_fdone = 0, n_ss_rise = 0;
    int fall_cyc, rise_cyc, start_cyc, take_cyc, rxv_cyc, fdone_cyc, busy_fall_cyc, sdone_cyc;
    logic ss_prev   = 1'b1;
    logic busy_prev = 1'b0;
    logic [7:0] exp_tb, exp_rb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] tx, input logic [7:0] rx, input bit expect_rx);
        feed.push_back(tx);
        exp_tx.push_back(tx);
        resp.push_back(rx);
        if (expect_rx) exp_rx.push_back(rx);
    endtask

    task automatic wait_fdone(input int base, input string tag);
        for (int i = 0; i < BOUND && n_fdone <= base; i++) @(negedge clk);
        @(negedge clk);
        check(tag, 32'(n_fdone > base), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < BOUND && ifc.frm_busy !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        check(tag, 32'(ifc.frm_busy), 32'd0);
    endtask

    task automatic wait_start(input int target, input string tag);
        for (int i = 0; i < BOUND && n_start < target; i++) @(negedge clk);
        check(tag, 32'(n_start >= target), 32'd1);
    endtask

    task automatic wait_rxv(input int target, input string tag);
        for (int i = 0; i < BOUND && n_rxv < target; i++) @(negedge clk);
        check(tag, 32'(n_rxv >= target), 32'd1);
    endtask

    // Requester tx source: offers the head of the feed queue and pops it when the sequencer takes it
    always @(negedge clk) begin
        if (ifc.tx_take === 1'b1 && feed.size() > 0) void'(feed.pop_front());
        ifc.tx_valid = (feed.size() > 0);
        ifc.tx_byte  = (feed.size() > 0) ? feed[0] : 8'h00;
    end

    // Byte-engine model: done arrives three cycles after start, and the reply comes from the resp queue
    logic [7:0] sl_resp;
    int         sl_cnt;
    bit         sl_busy;
    always @(negedge clk) begin
        if (reset) begin
            sl_busy          = 1'b0;
            sl_cnt           = 0;
            ifc.spi_done     = 1'b0;
            ifc.spi_tx_ready = 1'b1;
            ifc.spi_rx_data  = 8'h00;
        end else begin
            ifc.spi_done = 1'b0;
            if (sl_busy) begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    ifc.spi_done     = 1'b1;
                    ifc.spi_rx_data  = sl_resp;
                    ifc.spi_tx_ready = 1'b1;
                    sl_busy          = 1'b0;
                    sdone_cyc        = cyc;
                end
            end else if (ifc.spi_start === 1'b1) begin
                sl_busy          = 1'b1;
                sl_cnt           = 3;
                ifc.spi_tx_ready = 1'b0;
                sl_resp          = 8'h00;
                if (resp.size() > 0) sl_resp = resp.pop_front();
            end
        end
    end

    // Monitor: event counts, timestamps and scoreboard comparisons
    always @(negedge clk) begin
        if (!reset) begin
            if (ss_prev && !ifc.ss_n) fall_cyc = cyc;
            if (!ss_prev && ifc.ss_n) begin
                rise_cyc = cyc;
                n_ss_rise++;
            end
            if (ifc.spi_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
                check("launch_expected", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0) begin
                    exp_tb = exp_tx.pop_front();
                    check("spi_tx_data", 32'(ifc.spi_tx_data), 32'(exp_tb));
                end
            end
            if (ifc.tx_take === 1'b1) begin
                n_take++;
                take_cyc = cyc;
            end
            if (ifc.rx_valid === 1'b1) begin
                n_rxv++;
                rxv_cyc = cyc;
                check("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
                if (exp_rx.size() > 0) begin
                    exp_rb = exp_rx.pop_front();
                    check("rx_byte", 32'(ifc.rx_byte), 32'(exp_rb));
                end
            end
            if (ifc.frm_done === 1'b1) begin
                n_fdone++;
                fdone_cyc = cyc;
            end
            if (busy_prev && !ifc.frm_busy) busy_fall_cyc = cyc;
        end
        ss_prev   = ifc.ss_n;
        busy_prev = ifc.frm_busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    int b_start, b_take, b_rxv, b_fd, b_rise, req_cyc, saved_rise;

    initial begin
        reset         = 1'b1;
        ifc.frm_req   = 1'b0;
        ifc.frm_len   = '0;
        ifc.frm_abort = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ss_n",     32'(ifc.ss_n),        32'd1);
        check("rst_busy",     32'(ifc.frm_busy),    32'd0);
        check("rst_done",     32'(ifc.frm_done),    32'd0);
        check("rst_take",     32'(ifc.tx_take),     32'd0);
        check("rst_rxv",      32'(ifc.rx_valid),    32'd0);
        check("rst_start",    32'(ifc.spi_start),   32'd0);
        check("rst_tx_data",  32'(ifc.spi_tx_data), 32'd0);
        check("rst_rx_byte",  32'(ifc.rx_byte),     32'd0);

        // Single byte A5, echo 3C
        push_byte(8'hA5, 8'h3C, 1'b1);
        @(negedge clk);
        b_fd        = n_fdone;
        ifc.frm_len = 4'd1;
        ifc.frm_req = 1'b1;
        req_cyc     = cyc;
        @(negedge clk);
        ifc.frm_req = 1'b0;
        check("t1_ss_low", 32'(ifc.ss_n), 32'd0);
        wait_fdone(b_fd, "t1_frame_done");
        check("t1_fall_after_req",   32'(fall_cyc - req_cyc),   32'd1);
        check("t1_setup_cycles",     32'(start_cyc - fall_cyc), 32'(CS_SETUP));
        check("t1_take_with_start",  32'(take_cyc - start_cyc), 32'd0);
        check("t1_rxv_after_done",   32'(rxv_cyc - sdone_cyc),  32'd1);
        check("t1_hold_cycles",      32'(rise_cyc - rxv_cyc),   32'(CS_HOLD));
        check("t1_fdone_at_rise",    32'(fdone_cyc - rise_cyc), 32'd0);
        wait_idle("t1_idle");
        check("t1_busy_fall",        32'(busy_fall_cyc - rise_cyc), 32'(IDLE_GAP));
        check("t1_tx_data_held",     32'(ifc.spi_tx_data), 32'hA5);

        // Three bytes with a tx_valid gap before byte 2
        b_start = n_start; b_take = n_take; b_rxv = n_rxv; b_fd = n_fdone; b_rise = n_ss_rise;
        push_byte(8'h01, 8'hE1, 1'b1);
        ifc.frm_len = 4'd3;
        ifc.frm_req = 1'b1;
        @(negedge clk);
        ifc.frm_req = 1'b0;
        wait_rxv(b_rxv + 1, "t2_byte1_rx");
        repeat (10) @(negedge clk);
        check("t2_no_launch_gap", 32'(n_start - b_start), 32'd1);
        check("t2_ss_low_stall",  32'(ifc.ss_n),          32'd0);
        push_byte(8'h02, 8'hE2, 1'b1);
        push_byte(8'h03, 8'hE3, 1'b1);
        wait_fdone(b_fd, "t2_frame_done");
        wait_idle("t2_idle");
        check("t2_takes",   32'(n_take - b_take),     32'd3);
        check("t2_starts",  32'(n_start - b_start),   32'd3);
        check("t2_rxvs",    32'(n_rxv - b_rxv),       32'd3);
        check("t2_fdones",  32'(n_fdone - b_fd),      32'd1);
        check("t2_ss_rise", 32'(n_ss_rise - b_rise),  32'd1);

        // Zero-length request held for five cycles
        b_start = n_start; b_take = n_take; b_fd = n_fdone;
        ifc.frm_len = 4'd0;
        ifc.frm_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_ss_high", 32'(ifc.ss_n),     32'd1);
            check("t3_busy",    32'(ifc.frm_busy), 32'd0);
        end
        ifc.frm_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_takes",  32'(n_take - b_take),   32'd0);
        check("t3_fdones", 32'(n_fdone - b_fd),    32'd0);
        check("t3_starts", 32'(n_start - b_start), 32'd0);

        // Abort during byte 2 of a five-byte frame; a third byte is offered but must not launch
        b_start = n_start; b_take = n_take; b_rxv = n_rxv; b_fd = n_fdone;
        push_byte(8'h11, 8'h91, 1'b1);
        push_byte(8'h22, 8'h92, 1'b1);
        feed.push_back(8'h33);
        ifc.frm_len = 4'd5;
        ifc.frm_req = 1'b1;
        @(negedge clk);
        ifc.frm_req = 1'b0;
        wait_start(b_start + 2, "t4_byte2_start");
        ifc.frm_abort = 1'b1;
        wait_rxv(b_rxv + 2, "t4_byte2_rx");
        ifc.frm_abort = 1'b0;
        wait_fdone(b_fd, "t4_frame_done");
        wait_idle("t4_idle");
        check("t4_takes",  32'(n_take - b_take),   32'd2);
        check("t4_starts", 32'(n_start - b_start), 32'd2);
        check("t4_rxvs",   32'(n_rxv - b_rxv),     32'd2);
        check("t4_fdones", 32'(n_fdone - b_fd),    32'd1);
        feed.delete();
        @(negedge clk);

        // Back-to-back frames with frm_req held high
        b_start = n_start; b_fd = n_fdone;
        push_byte(8'h44, 8'hC4, 1'b1);
        push_byte(8'h55, 8'hC5, 1'b1);
        ifc.frm_len = 4'd1;
        ifc.frm_req = 1'b1;
        wait_fdone(b_fd, "t5_frame1_done");
        saved_rise = rise_cyc;
        for (int i = 0; i < BOUND && ifc.ss_n !== 1'b0; i++) @(negedge clk);
        ifc.frm_req = 1'b0;
        @(negedge clk);
        check("t5_gap_high_cycles", 32'(fall_cyc - saved_rise), 32'(IDLE_GAP + 1));
        wait_fdone(b_fd + 1, "t5_frame2_done");
        wait_idle("t5_idle");
        check("t5_starts",  32'(n_start - b_start), 32'd2);
        check("t5_fdones",  32'(n_fdone - b_fd),    32'd2);

        // Reset while byte 1 is in flight, then a clean two-byte frame
        b_fd = n_fdone;
        push_byte(8'h66, 8'h00, 1'b0);
        ifc.frm_len = 4'd2;
        ifc.frm_req = 1'b1;
        @(negedge clk);
        ifc.frm_req = 1'b0;
        wait_start(n_start + 1, "t6_byte1_start");
        @(negedge clk);
        check("t6_ss_low_pre", 32'(ifc.ss_n), 32'd0);
        reset = 1'b1;
        #1;
        check("t6_ss_async",  32'(ifc.ss_n),      32'd1);
        check("t6_start0",    32'(ifc.spi_start), 32'd0);
        check("t6_take0",     32'(ifc.tx_take),   32'd0);
        check("t6_rxv0",      32'(ifc.rx_valid),  32'd0);
        check("t6_fdone0",    32'(ifc.frm_done),  32'd0);
        check("t6_busy0",     32'(ifc.frm_busy),  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_no_fdone", 32'(n_fdone - b_fd), 32'd0);
        b_start = n_start; b_rxv = n_rxv; b_fd = n_fdone;
        push_byte(8'h77, 8'hA7, 1'b1);
        push_byte(8'h88, 8'hA8, 1'b1);
        ifc.frm_len = 4'd2;
        ifc.frm_req = 1'b1;
        @(negedge clk);
        ifc.frm_req = 1'b0;
        wait_fdone(b_fd, "t6_frame_done");
        wait_idle("t6_idle");
        check("t6_starts", 32'(n_start - b_start), 32'd2);
        check("t6_rxvs",   32'(n_rxv - b_rxv),     32'd2);
        check("t6_fdones", 32'(n_fdone - b_fd),    32'd1);

        check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
        check("exp_rx_drained", 32'(exp_rx.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
